// File: rtl/mm_result_drain.sv
// Result drain: snapshots the N*N accumulator/exponent results when done rises,
// then streams them row-major over valid/ready. The optional out_parity port is built when DRAIN_PARITY_EN is defined.
module mm_result_drain #(
    parameter int ACC_WIDTH = 32,
    parameter int EXP_WIDTH = 5,
    parameter int N         = 2,
    parameter int IDX_W     = ((N * N) > 1) ? $clog2(N * N) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done,
    input  logic [N*N*ACC_WIDTH-1:0]     acc_in,
    input  logic [N*N*EXP_WIDTH-1:0]     exp_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_acc,
    output logic [EXP_WIDTH-1:0]         out_exp,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun
`ifdef DRAIN_PARITY_EN
    ,
    output logic                         out_parity
`endif
);

    localparam int NE = N * N;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   done_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   overrun_q, overrun_d;
    logic [ACC_WIDTH-1:0]   acc_buf_q [NE];
    logic [ACC_WIDTH-1:0]   acc_buf_d [NE];
    logic [EXP_WIDTH-1:0]   exp_buf_q [NE];
    logic [EXP_WIDTH-1:0]   exp_buf_d [NE];

    logic                   done_rise_s;
    logic                   capture_s;
    logic                   busy_s;
    logic                   last_s;
    logic                   handshake_s;

    function automatic logic parity_f(input logic [EXP_WIDTH+ACC_WIDTH-1:0] v);
        return ^v;
    endfunction

    // Rising-edge detect on the level done and decode of the current element.
    always_comb begin
        done_rise_s = done & ~done_q;
        busy_s      = (state_q == DRAIN);
        last_s      = busy_s && (idx_q == IDX_W'(NE - 1));
        handshake_s = busy_s & out_ready;
    end

    // Next-state logic: capture in IDLE, walk the buffer in DRAIN, flag late jobs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_rise_s) begin
                    capture_s = 1'b1;
                    state_d   = DRAIN;
                    idx_d     = {IDX_W{1'b0}};
                end else begin
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                // A completion arriving mid-drain (even on the final beat) is dropped.
                if (done_rise_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                if (handshake_s && last_s) begin
                    state_d = IDLE;
                    idx_d   = {IDX_W{1'b0}};
                end else if (handshake_s) begin
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    idx_d   = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Snapshot buffer next value: whole result set replaced only on capture.
    always_comb begin
        acc_buf_d = acc_buf_q;
        exp_buf_d = exp_buf_q;
        if (capture_s) begin
            for (int e = 0; e < NE; e++) begin
                acc_buf_d[e] = acc_in[e*ACC_WIDTH +: ACC_WIDTH];
                exp_buf_d[e] = exp_in[e*EXP_WIDTH +: EXP_WIDTH];
            end
        end else begin
            acc_buf_d = acc_buf_q;
            exp_buf_d = exp_buf_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            idx_q     <= {IDX_W{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    // Result buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < NE; e++) begin
                acc_buf_q[e] <= {ACC_WIDTH{1'b0}};
                exp_buf_q[e] <= {EXP_WIDTH{1'b0}};
            end
        end else begin
            acc_buf_q <= acc_buf_d;
            exp_buf_q <= exp_buf_d;
        end
    end

    // Output view: buffered element while draining, zeros otherwise.
    always_comb begin
        out_valid = busy_s;
        busy      = busy_s;
        out_idx   = idx_q;
        out_last  = last_s;
        overrun   = overrun_q;
        if (busy_s) begin
            out_acc = acc_buf_q[idx_q];
            out_exp = exp_buf_q[idx_q];
        end else begin
            out_acc = {ACC_WIDTH{1'b0}};
            out_exp = {EXP_WIDTH{1'b0}};
        end
`ifdef DRAIN_PARITY_EN
        out_parity = parity_f({out_exp, out_acc});
`endif
    end

endmodule

// File: tb/tb_mm_result_drain.sv
// Bench for mm_result_drain: directed test-plan steps plus a random phase, checked
// against a queue-based model of the snapshot-and-stream behaviour.
module tb_mm_result_drain;

    localparam int AW = 32;
    localparam int EW = 5;
    localparam int N  = 2;
    localparam int NE = N * N;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic              done;
    logic [NE*AW-1:0]  acc_in;
    logic [NE*EW-1:0]  exp_in;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_acc;
    logic [EW-1:0]     out_exp;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic              busy;
    logic              overrun;
`ifdef DRAIN_PARITY_EN
    logic              out_parity;
`endif

    mm_result_drain #(.ACC_WIDTH(AW), .EXP_WIDTH(EW), .N(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .done(done), .acc_in(acc_in), .exp_in(exp_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_exp(out_exp), .out_idx(out_idx), .out_last(out_last),
        .busy(busy), .overrun(overrun)
`ifdef DRAIN_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: pending elements of the current job, in delivery order.
    logic [AW-1:0] m_acc [$];
    logic [EW-1:0] m_exp [$];
    int            m_idx;
    bit            m_overrun;
    bit            m_done_prev;
    int            handshakes;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_acc.delete();
        m_exp.delete();
        m_idx       = 0;
        m_overrun   = 1'b0;
        m_done_prev = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        bit act;
        act = (m_acc.size() != 0);
        chk({tag, ".valid"},   {63'd0, out_valid}, {63'd0, act});
        chk({tag, ".busy"},    {63'd0, busy},      {63'd0, act});
        chk({tag, ".idx"},     {62'd0, out_idx},   64'(m_idx));
        chk({tag, ".last"},    {63'd0, out_last},  {63'd0, act && (m_acc.size() == 1)});
        chk({tag, ".overrun"}, {63'd0, overrun},   {63'd0, m_overrun});
        chk({tag, ".acc"},     {32'd0, out_acc},   act ? {32'd0, m_acc[0]} : 64'd0);
        chk({tag, ".exp"},     {59'd0, out_exp},   act ? {59'd0, m_exp[0]} : 64'd0);
`ifdef DRAIN_PARITY_EN
        chk({tag, ".parity"},  {63'd0, out_parity},
            act ? {63'd0, ^{m_exp[0], m_acc[0]}} : 64'd0);
`endif
    endtask

    // Advance one clock with the currently driven inputs, updating the model alongside.
    task automatic step(input string tag);
        bit rise;
        rise = done && !m_done_prev;
        if (m_acc.size() != 0) begin
            if (rise) m_overrun = 1'b1;
            if (out_ready) begin
                void'(m_acc.pop_front());
                void'(m_exp.pop_front());
                handshakes++;
                m_idx = (m_acc.size() == 0) ? 0 : m_idx + 1;
            end
        end else if (rise) begin
            for (int e = 0; e < NE; e++) begin
                m_acc.push_back(acc_in[e*AW +: AW]);
                m_exp.push_back(exp_in[e*EW +: EW]);
            end
            m_idx = 0;
        end
        m_done_prev = done;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic load_basic();
        acc_in = {32'd40, 32'd30, 32'd20, 32'd10};
        exp_in = {5'd4, 5'd3, 5'd2, 5'd1};
    endtask

    initial begin
        bit [7:0] bp_pat;
        rst = 1'b0; done = 1'b0; out_ready = 1'b0;
        acc_in = '0; exp_in = '0;
        model_reset();
        handshakes = 0;
        #12;
        check_outputs("reset");
        rst = 1'b1;
        step("idle");

        // Basic drain: capture, then one element per cycle.
        load_basic();
        out_ready = 1'b1; done = 1'b1;
        step("basic_cap");
        chk("basic_first_acc", {32'd0, out_acc}, 64'd10);
        done = 1'b0;
        handshakes = 0;
        for (int i = 0; i < 5; i++) step("basic");
        chk("basic_hs_count", 64'(handshakes), 64'd4);
        chk("basic_busy_after", {63'd0, busy}, 64'd0);

        // Backpressure pattern 0,0,1,0,1,1,0,1; data change after capture must not leak in.
        load_basic();
        out_ready = 1'b0; done = 1'b1;
        step("bp_cap");
        done = 1'b0;
        acc_in = {NE{32'hFFFF_FFFF}};
        handshakes = 0;
        bp_pat = 8'b1011_0100;
        for (int i = 0; i < 8; i++) begin
            out_ready = bp_pat[i];
            step("bp");
        end
        chk("bp_hs_count", 64'(handshakes), 64'd4);

        // Level done held for 12 cycles: exactly one drain, no overrun.
        load_basic();
        out_ready = 1'b1; done = 1'b1;
        handshakes = 0;
        for (int i = 0; i < 12; i++) step("level");
        done = 1'b0;
        step("level_end");
        chk("level_hs_count", 64'(handshakes), 64'd4);
        chk("level_overrun", {63'd0, overrun}, 64'd0);

        // Overrun: second completion while stalled at idx1.
        load_basic();
        out_ready = 1'b0; done = 1'b1;
        step("ovr_cap");
        done = 1'b0; out_ready = 1'b1;
        step("ovr_adv");
        out_ready = 1'b0;
        acc_in = {32'd4, 32'd3, 32'd2, 32'd1};
        done = 1'b1;
        step("ovr_hit");
        chk("ovr_flag", {63'd0, overrun}, 64'd1);
        done = 1'b0;
        step("ovr_hold");
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step("ovr_drain");
        chk("ovr_sticky", {63'd0, overrun}, 64'd1);

        // Asynchronous reset at idx2, between clock edges.
        load_basic();
        done = 1'b1;
        step("rst_cap");
        done = 1'b0;
        step("rst_d0");
        step("rst_d1");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        #1;
        rst = 1'b1;
        step("rst_idle");
        done = 1'b1;
        step("rst_recap");
        done = 1'b0;
        for (int i = 0; i < 5; i++) step("rst_drain");

        // Random traffic: random data, sparse done pulses, random ready.
        for (int i = 0; i < 300; i++) begin
            for (int e = 0; e < NE; e++) begin
                acc_in[e*AW +: AW] = $urandom;
                exp_in[e*EW +: EW] = EW'($urandom);
            end
            done      = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
